// File: rtl/sub16_serial_if.sv
// sub16_serial_if: operand/result handshake bundle for the bit-serial subtractor.
interface sub16_serial_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        borrow;
    logic        zero;
    logic        neg;
    logic        ovf;
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, zero, neg, ovf
    );
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, zero, neg, ovf
    );
endinterface

// File: rtl/sub16_serial.sv
// sub16_serial: bit-serial 16-bit subtractor, LSB first through one full-subtractor cell and a borrow flop.
module sub16_serial (
    input logic           clk,
    input logic           rst_n,
    sub16_serial_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      r_state;
    logic [15:0] r_a, r_b, r_res, r_diff;
    logic [3:0]  r_cnt;
    logic        r_br, r_a15, r_b15, r_in_ready, r_out_valid;
    logic        r_borrow, r_zero, r_neg, r_ovf;
    logic        w_d, w_br;
    logic [15:0] w_res;
    assign w_d   = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_res = {w_d, r_res[15:1]};
    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.diff      = r_diff;
    assign bus.borrow    = r_borrow;
    assign bus.zero      = r_zero;
    assign bus.neg       = r_neg;
    assign bus.ovf       = r_ovf;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_diff      <= '0;
            r_cnt       <= '0;
            r_br        <= 1'b0;
            r_a15       <= 1'b0;
            r_b15       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_borrow    <= 1'b0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_a        <= bus.a;
                    r_b        <= bus.b;
                    r_br       <= 1'b0;
                    r_cnt      <= '0;
                    r_a15      <= bus.a[15];
                    r_b15      <= bus.b[15];
                    r_in_ready <= 1'b0;
                    r_state    <= RUN;
                end
                RUN: begin
                    r_a   <= {1'b0, r_a[15:1]};
                    r_b   <= {1'b0, r_b[15:1]};
                    r_res <= w_res;
                    r_br  <= w_br;
                    r_cnt <= r_cnt + 4'd1;
                    // counter wraps to 0 exactly as bit 15 retires
                    if (r_cnt == 4'd15) begin
                        r_diff      <= w_res;
                        r_borrow    <= w_br;
                        r_zero      <= (w_res == 16'h0000);
                        r_neg       <= w_d;
                        r_ovf       <= (r_a15 != r_b15) && (w_d != r_a15);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: if (bus.out_ready) begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sub16_serial.sv
// tb_sub16_serial: directed and randomized checks of sub16_serial against an arithmetic reference model.
module tb_sub16_serial;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    sub16_serial_if bus ();
    sub16_serial u_dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;

    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] d;
        int          s;
        d = a - b;
        s = int'($signed(a)) - int'($signed(b));
        return {d, a < b, d == 16'h0000, d[15], (s > 32767) || (s < -32768)};
    endfunction

    function automatic logic [19:0] observed();
        return {bus.diff, bus.borrow, bus.zero, bus.neg, bus.ovf};
    endfunction

    task automatic send(input logic [15:0] a, input logic [15:0] b, output bit ok);
        int n = 0;
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = bus.in_ready;
        bus.a = a;
        bus.b = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a = 16'($urandom);
        bus.b = 16'($urandom);
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid, observed()} !== 22'h200000) begin
            failures++;
            $display("FAIL reset_values got ir=%b ov=%b res=%h want ir=1 ov=0 res=00000",
                     bus.in_ready, bus.out_valid, observed());
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            failures++;
            $display("FAIL reset_release got ir=%b ov=%b want ir=1 ov=0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int cyc;
        bus.out_ready = 1'b1;
        send(16'h0005, 16'h0003, ok);
        wait_out(cyc);
        checks++;
        if (!ok || cyc != 16) begin
            failures++;
            $display("FAIL basic_latency got ok=%0d cyc=%0d want ok=1 cyc=16", ok, cyc);
        end
        checks++;
        if (observed() !== {16'h0002, 4'b0000}) begin
            failures++;
            $display("FAIL basic_result got %h want 00020", observed());
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_ready_in_done got %b want 0", bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            failures++;
            $display("FAIL basic_return_idle got ir=%b ov=%b want ir=1 ov=0", bus.in_ready, bus.out_valid);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_directed(input logic [15:0] a, input logic [15:0] b, input logic [19:0] want);
        bit ok;
        int cyc;
        bus.out_ready = 1'b1;
        send(a, b, ok);
        wait_out(cyc);
        checks++;
        if (!ok || cyc != 16 || observed() !== want) begin
            failures++;
            $display("FAIL directed_%h_%h got ok=%0d cyc=%0d res=%h want ok=1 cyc=16 res=%h",
                     a, b, ok, cyc, observed(), want);
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_equal_backpressure();
        bit          ok;
        int          cyc;
        logic [19:0] snap;
        bus.out_ready = 1'b0;
        send(16'hA5A5, 16'hA5A5, ok);
        repeat (3) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
        end
        wait_out(cyc);
        checks++;
        if (!ok || cyc != 13 || observed() !== {16'h0000, 4'b0100}) begin
            failures++;
            $display("FAIL equal_result got ok=%0d cyc=%0d res=%h want ok=1 cyc=13 res=00004",
                     ok, cyc, observed());
        end
        snap = observed();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || observed() !== snap) begin
                failures++;
                $display("FAIL equal_hold_%0d got ov=%b ir=%b res=%h want ov=1 ir=0 res=%h",
                         i, bus.out_valid, bus.in_ready, observed(), snap);
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10 || observed() !== snap) begin
            failures++;
            $display("FAIL equal_release got ir=%b ov=%b res=%h want ir=1 ov=0 res=%h",
                     bus.in_ready, bus.out_valid, observed(), snap);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_midrun();
        bit ok;
        int cyc;
        send(16'h1234, 16'h0001, ok);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, observed()} !== 22'h200000) begin
            failures++;
            $display("FAIL midrun_async_reset got ir=%b ov=%b res=%h want ir=1 ov=0 res=00000",
                     bus.in_ready, bus.out_valid, observed());
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        send(16'hFFFF, 16'hFFFF, ok);
        wait_out(cyc);
        checks++;
        if (!ok || cyc != 16 || observed() !== {16'h0000, 4'b0100}) begin
            failures++;
            $display("FAIL midrun_after_reset got ok=%0d cyc=%0d res=%h want ok=1 cyc=16 res=00004",
                     ok, cyc, observed());
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] qa[$];
        logic [15:0] qb[$];
        logic [15:0] ea, eb;
        logic [19:0] snap;
        bit          ok;
        int          cyc, accepted, results;
        accepted = 0;
        results = 0;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ea = 16'($urandom);
            eb = 16'($urandom);
            if (i % 50 == 0) eb = ea;
            send(ea, eb, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL rand_accept_%0d got in_ready=0 want 1", i);
            end
            qa.push_back(ea);
            qb.push_back(eb);
            accepted++;
            bus.out_ready = 1'($urandom);
            wait_out(cyc);
            bus.out_ready = 1'b0;
            checks++;
            if (cyc != 16) begin
                failures++;
                $display("FAIL rand_latency_%0d got %0d want 16", i, cyc);
            end
            snap = observed();
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                checks++;
                if (bus.out_valid !== 1'b1 || observed() !== snap) begin
                    failures++;
                    $display("FAIL rand_stall_%0d got ov=%b res=%h want ov=1 res=%h",
                             i, bus.out_valid, observed(), snap);
                end
            end
            bus.out_ready = 1'b1;
            ea = qa.pop_front();
            eb = qb.pop_front();
            results++;
            checks++;
            if (observed() !== model(ea, eb)) begin
                failures++;
                $display("FAIL rand_result_%0d a=%h b=%h got %h want %h", i, ea, eb, observed(), model(ea, eb));
            end
            @(negedge clk);
            bus.out_ready = 1'b0;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL rand_single_result_%0d got ov=%b want 0", i, bus.out_valid);
            end
        end
        checks++;
        if (accepted != results || qa.size() != 0) begin
            failures++;
            $display("FAIL rand_count got results=%0d pending=%0d want results=%0d pending=0",
                     results, qa.size(), accepted);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_directed(16'h0003, 16'h0005, {16'hFFFE, 4'b1010});
        test_directed(16'h8000, 16'h0001, {16'h7FFF, 4'b0001});
        test_equal_backpressure();
        test_reset_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end
endmodule
